id_hazard_ctrl: RTL and testbench
=================================

# id_hazard_ctrl

Parametrised operand-hazard controller for the decode (ID) stage. It resolves each source operand by forwarding from any number of downstream pipeline stages. A per-register countdown scoreboard tracks in-flight multi-cycle writers (loads, multi-cycle arithmetic) and raises a decode stall until their results become forwardable. It sits between the register file read ports and the ID/EX pipeline register, and replaces fixed two-port, load-only stall detection with a generic latency-driven scheme.

## Interface
- NUM_RD, 2, number of operand read ports
- NUM_FWD, 2, number of forwarding sources; index 0 = youngest stage (EX), highest priority
- REG_AW, 5, register address width; register file has 2**REG_AW entries
- DATA_W, 32, operand width
- MAX_LAT, 7, maximum writer latency in cycles; CNT_W = clog2(MAX_LAT+1)

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- issue_valid  in  1  instruction present in ID
- issue_wreg  in  1  instruction writes a register
- issue_wd  in  REG_AW  destination register
- issue_lat  in  CNT_W  cycles before result is forwardable (0 = forwardable next cycle)
- flush_i  in  1  pipeline flush; clears scoreboard
- rd_en  in  NUM_RD  per-port read enable
- rd_addr  in  NUM_RD*REG_AW  per-port source register
- rf_data  in  NUM_RD*DATA_W  register file read data
- fwd_wreg  in  NUM_FWD  per-source write enable
- fwd_wd  in  NUM_FWD*REG_AW  per-source destination
- fwd_wdata  in  NUM_FWD*DATA_W  per-source result
- operand_o  out  NUM_RD*DATA_W  resolved operands
- stall_o  out  1  decode stall request
- issue_fire_o  out  1  issue_valid & ~stall_o & ~flush_i

## Operation
- Scoreboard: one CNT_W counter per register; register 0 has none and is never busy.
- Issue: on issue_fire_o with issue_wreg=1, issue_wd≠0 and issue_lat>0, cnt[issue_wd] ← min(issue_lat, MAX_LAT). issue_lat=0 leaves the entry untouched.
- Every cycle, each nonzero counter decrements by 1. A same-cycle issue to a decrementing entry takes priority and loads the new value.
- Port hazard p: rd_en[p] & rd_addr[p]≠0 & cnt[rd_addr[p]]≠0.
- stall_o = issue_valid & OR(port hazards) & ~flush_i.
- Operand resolution per port, first match wins:
  - rd_en=0 → 0.
  - rd_addr=0 → 0.
  - Lowest-index fwd source with fwd_wreg=1 and fwd_wd=rd_addr → fwd_wdata.
  - Otherwise rf_data.
- operand_o is valid even while stalling; the consumer ignores it.
- flush_i: all counters cleared at the next edge. No issue is recorded in a flush cycle.

## Timing
- operand_o, stall_o and issue_fire_o are combinational from the current inputs and scoreboard state; no added latency.
- Scoreboard updates on the rising clk edge.
- A writer fired at cycle t with lat L stalls dependents during cycles t+1 … t+L. The dependent reads at t+L+1 and gets its value through forwarding.
- Load example: L=1 gives exactly one bubble.
- Reset, including mid-operation: all counters 0 at the next edge. stall_o then depends only on inputs and is 0 with an empty scoreboard. stall_cnt_o is 0.
- Back-to-back writers to the same register: the later issue overwrites the counter.
- A writer to the register it reads does not self-stall; the hazard is evaluated against the pre-edge state.

## Configuration
- ID_HAZ_PERF_EN defined: adds output stall_cnt_o (32 bits).
  - Increments on every cycle with stall_o=1.
  - Saturates at 32'hFFFFFFFF.
  - Cleared by rst only.
- ID_HAZ_PERF_EN undefined: the port and counter are absent.

## Structure
- Shared package id_pkg holds REG_AW, DATA_W, ZeroWord, the NOP register address, and the clog2 function. The EX/MEM stages use the same definitions.
- One sub-module, id_fwd_mux: single-port priority forwarding mux parameterised by NUM_FWD. It is instantiated NUM_RD times.
- The scoreboard counter array and stall logic stay in the top level.

## Test plan
- Default parameters. Issue a load: wd=5, lat=1. Next cycle read r5 on port 0 → stall_o=1 for 1 cycle. Following cycle, with fwd[1] wd=5 data=0xDEADBEEF → operand_o[0]=0xDEADBEEF, stall_o=0.
- ALU writer, lat=0, wd=3, then an immediate dependent read of r3 with fwd[0] data=0x12 → no stall, operand=0x12.
- Both fwd sources target r7, with fwd[0]=0xAAAA and fwd[1]=0xBBBB → operand=0xAAAA.
- Issue lat=6 to r9 at t. At t+2 assert flush_i. At t+3 read r9 → no stall.
- Read of r0 with every fwd source targeting r0 with data 0xFFFF → operand=0, no stall.
- Issue lat=4 to r2. Assert rst at the 2nd stall cycle → stall_o=0 the cycle after reset. With ID_HAZ_PERF_EN defined, stall_cnt_o=0 after reset and equals 4 after an uninterrupted lat=4 stall.

Source files
------------

// File: rtl/id_hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// id_pkg
// Shared decode/execute definitions. The EX and MEM stages import the same
// package, so register address width, operand width, the zero word and the
// NOP register address stay consistent across the pipeline.
//
// Contents:
//   REG_AW    register address width (register file has 2**REG_AW entries)
//   DATA_W    operand width
//   ZeroWord  all-zero operand
//   NOP_REG   hard-wired zero register address
//   clog2     constant ceil(log2(v)) helper for sizing counters
// -----------------------------------------------------------------------------
package id_pkg;

    localparam int REG_AW = 5;
    localparam int DATA_W = 32;

    localparam logic [DATA_W-1:0] ZeroWord = '0;
    localparam logic [REG_AW-1:0] NOP_REG  = '0;

    // ceil(log2(v)); clog2(1) = 0, clog2(8) = 3
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/id_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// id_hazard_ctrl_if
// Bundle of the signals between the decode stage and the operand hazard
// controller: issue request, read ports, register file data, forwarding
// sources and the resolved results.
//
// Issue handshake: issue_valid says an instruction sits in ID. It is accepted
// (moves to EX and, if it writes, is recorded in the scoreboard) in exactly
// the cycles where issue_fire_o = issue_valid & ~stall_o & ~flush_i. While it
// is not accepted the decode stage holds the instruction and its inputs.
//
// Modports:
//   master  decode stage side: drives issue/read/forward inputs
//   slave   hazard controller: drives operand_o, stall_o, issue_fire_o
// -----------------------------------------------------------------------------
interface id_hazard_ctrl_if
    import id_pkg::*;
#(
    parameter int NUM_RD  = 2,
    parameter int NUM_FWD = 2,
    parameter int CNT_W   = 3
);

    logic                      issue_valid;
    logic                      issue_wreg;
    logic [REG_AW-1:0]         issue_wd;
    logic [CNT_W-1:0]          issue_lat;
    logic                      flush_i;
    logic [NUM_RD-1:0]         rd_en;
    logic [NUM_RD*REG_AW-1:0]  rd_addr;
    logic [NUM_RD*DATA_W-1:0]  rf_data;
    logic [NUM_FWD-1:0]        fwd_wreg;
    logic [NUM_FWD*REG_AW-1:0] fwd_wd;
    logic [NUM_FWD*DATA_W-1:0] fwd_wdata;
    logic [NUM_RD*DATA_W-1:0]  operand_o;
    logic                      stall_o;
    logic                      issue_fire_o;

    modport master (
        output issue_valid, issue_wreg, issue_wd, issue_lat, flush_i,
        output rd_en, rd_addr, rf_data, fwd_wreg, fwd_wd, fwd_wdata,
        input  operand_o, stall_o, issue_fire_o
    );

    modport slave (
        input  issue_valid, issue_wreg, issue_wd, issue_lat, flush_i,
        input  rd_en, rd_addr, rf_data, fwd_wreg, fwd_wd, fwd_wdata,
        output operand_o, stall_o, issue_fire_o
    );

endinterface

// File: rtl/id_hazard_ctrl_fwd_mux.sv
// -----------------------------------------------------------------------------
// id_fwd_mux
// Single read port operand resolution. Returns zero for a disabled port or a
// read of the zero register, otherwise the result of the youngest matching
// forwarding source (lowest index), otherwise the register file data.
//
// Ports:
//   rd_en_i      read enable
//   rd_addr_i    source register
//   rf_data_i    register file read data
//   fwd_wreg_i   per-source write enable
//   fwd_wd_i     per-source destination register
//   fwd_wdata_i  per-source result
//   operand_o    resolved operand
// -----------------------------------------------------------------------------
module id_fwd_mux
    import id_pkg::*;
#(
    parameter int NUM_FWD = 2
) (
    input  logic                      rd_en_i,
    input  logic [REG_AW-1:0]         rd_addr_i,
    input  logic [DATA_W-1:0]         rf_data_i,
    input  logic [NUM_FWD-1:0]        fwd_wreg_i,
    input  logic [NUM_FWD*REG_AW-1:0] fwd_wd_i,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata_i,
    output logic [DATA_W-1:0]         operand_o
);

    always_comb begin
        operand_o = rf_data_i;
        // Walk from the oldest source to the youngest so the lowest index
        // match is the last assignment and therefore wins.
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (fwd_wreg_i[i] && (fwd_wd_i[i*REG_AW +: REG_AW] == rd_addr_i)) begin
                operand_o = fwd_wdata_i[i*DATA_W +: DATA_W];
            end
        end
        // Zero register and idle ports never pick up forwarded garbage.
        if (!rd_en_i || (rd_addr_i == NOP_REG)) begin
            operand_o = ZeroWord;
        end
    end

endmodule

// File: rtl/id_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// id_hazard_ctrl
// Decode stage operand hazard controller. Each source operand is resolved by
// forwarding from downstream stages; a per-register countdown scoreboard
// tracks in-flight multi-cycle writers and stalls decode until their result
// reaches a forwarding source.
//
// Parameters: NUM_RD read ports, NUM_FWD forwarding sources (0 = youngest),
// MAX_LAT maximum writer latency. REG_AW/DATA_W come from id_pkg.
//
// Ports:
//   clk          clock
//   rst          synchronous active-high reset, clears the scoreboard
//   bus          id_hazard_ctrl_if.slave (issue, read ports, forwarding,
//                operand_o, stall_o, issue_fire_o)
//   stall_cnt_o  saturating count of stall cycles; only present when the
//                ID_HAZ_PERF_EN macro is defined
// -----------------------------------------------------------------------------
module id_hazard_ctrl
    import id_pkg::*;
#(
    parameter int NUM_RD  = 2,
    parameter int NUM_FWD = 2,
    parameter int MAX_LAT = 7
) (
    input  logic               clk,
    input  logic               rst,
    id_hazard_ctrl_if.slave    bus
`ifdef ID_HAZ_PERF_EN
    ,
    output logic [31:0]        stall_cnt_o
`endif
);

    localparam int CNT_W = clog2(MAX_LAT + 1);
    localparam int NREG  = 1 << REG_AW;
    localparam logic [CNT_W-1:0] MAX_LAT_C = CNT_W'(MAX_LAT);

    logic [CNT_W-1:0] cnt_q [NREG];
    logic [CNT_W-1:0] cnt_d [NREG];
    logic [CNT_W-1:0] lat_clamped;
    logic [NUM_RD-1:0] port_hazard;
    logic              stall;
    logic              fire;
    logic              record;

    // ---------------- hazard detection (pre-edge scoreboard) ----------------
    always_comb begin
        for (int p = 0; p < NUM_RD; p++) begin
            port_hazard[p] = bus.rd_en[p]
                          && (bus.rd_addr[p*REG_AW +: REG_AW] != NOP_REG)
                          && (cnt_q[bus.rd_addr[p*REG_AW +: REG_AW]] != '0);
        end
    end

    assign stall = bus.issue_valid & (|port_hazard) & ~bus.flush_i;
    assign fire  = bus.issue_valid & ~stall & ~bus.flush_i;

    assign bus.stall_o      = stall;
    assign bus.issue_fire_o = fire;

    // ---------------- scoreboard next state ----------------
    assign lat_clamped = (bus.issue_lat > MAX_LAT_C) ? MAX_LAT_C : bus.issue_lat;
    // A zero-latency writer is forwardable next cycle, so it never needs an entry.
    assign record = fire && bus.issue_wreg && (bus.issue_wd != NOP_REG)
                 && (bus.issue_lat != '0);

    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            cnt_d[r] = '0;
            if (r != 0 && !bus.flush_i) begin
                if (cnt_q[r] != '0) begin
                    cnt_d[r] = cnt_q[r] - 1'b1;
                end
                // A new issue overrides the decrement of the same entry.
                if (record && (bus.issue_wd == REG_AW'(r))) begin
                    cnt_d[r] = lat_clamped;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int r = 0; r < NREG; r++) begin
            if (rst) begin
                cnt_q[r] <= '0;
            end else begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    // ---------------- operand resolution ----------------
    for (genvar p = 0; p < NUM_RD; p++) begin : g_port
        id_fwd_mux #(
            .NUM_FWD (NUM_FWD)
        ) u_fwd_mux (
            .rd_en_i     (bus.rd_en[p]),
            .rd_addr_i   (bus.rd_addr[p*REG_AW +: REG_AW]),
            .rf_data_i   (bus.rf_data[p*DATA_W +: DATA_W]),
            .fwd_wreg_i  (bus.fwd_wreg),
            .fwd_wd_i    (bus.fwd_wd),
            .fwd_wdata_i (bus.fwd_wdata),
            .operand_o   (bus.operand_o[p*DATA_W +: DATA_W])
        );
    end

`ifdef ID_HAZ_PERF_EN
    // ---------------- stall performance counter ----------------
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // Flush does not clear it: it counts lost decode cycles across flushes.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_hazard_ctrl.sv
module tb_id_hazard_ctrl;
    import id_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    // {stall, fire, operand port1, operand port0}
    logic [65:0] exp_q[$];

    id_hazard_ctrl_if #(.NUM_RD(2), .NUM_FWD(2), .CNT_W(3)) bus ();

`ifdef ID_HAZ_PERF_EN
    logic [31:0] stall_cnt;
`endif

    id_hazard_ctrl #(
        .NUM_RD  (2),
        .NUM_FWD (2),
        .MAX_LAT (7)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef ID_HAZ_PERF_EN
        ,
        .stall_cnt_o (stall_cnt)
`endif
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        bus.issue_valid = 1'b0;
        bus.issue_wreg  = 1'b0;
        bus.issue_wd    = '0;
        bus.issue_lat   = '0;
        bus.flush_i     = 1'b0;
        bus.rd_en       = '0;
        bus.rd_addr     = '0;
        bus.rf_data     = '0;
        bus.fwd_wreg    = '0;
        bus.fwd_wd      = '0;
        bus.fwd_wdata   = '0;
    endtask

    task automatic set_issue(input logic v, input logic wreg, input logic [4:0] wd,
                             input logic [2:0] lat);
        bus.issue_valid = v;
        bus.issue_wreg  = wreg;
        bus.issue_wd    = wd;
        bus.issue_lat   = lat;
    endtask

    task automatic set_rd(input int p, input logic en, input logic [4:0] addr,
                          input logic [31:0] data);
        bus.rd_en[p]           = en;
        bus.rd_addr[p*5 +: 5]  = addr;
        bus.rf_data[p*32 +: 32] = data;
    endtask

    task automatic set_fwd(input int i, input logic wreg, input logic [4:0] wd,
                           input logic [31:0] data);
        bus.fwd_wreg[i]          = wreg;
        bus.fwd_wd[i*5 +: 5]     = wd;
        bus.fwd_wdata[i*32 +: 32] = data;
    endtask

    function automatic logic [65:0] mk(input logic stall, input logic fire,
                                       input logic [31:0] op0, input logic [31:0] op1);
        return {stall, fire, op1, op0};
    endfunction

    // Push the expectation for the inputs just driven, compare at the negedge,
    // then advance to just after the next rising edge.
    task automatic step(input string name, input logic [65:0] exp);
        logic [65:0] e;
        logic [65:0] got;
        exp_q.push_back(exp);
        @(negedge clk);
        got = {bus.stall_o, bus.issue_fire_o, bus.operand_o};
        e = exp_q.pop_front();
        n_checks++;
        if (got[65] !== e[65]) begin
            n_fail++;
            $display("FAIL %s stall_o: got %b expected %b", name, got[65], e[65]);
        end
        n_checks++;
        if (got[64] !== e[64]) begin
            n_fail++;
            $display("FAIL %s issue_fire_o: got %b expected %b", name, got[64], e[64]);
        end
        n_checks++;
        if (got[31:0] !== e[31:0]) begin
            n_fail++;
            $display("FAIL %s operand0: got %h expected %h", name, got[31:0], e[31:0]);
        end
        n_checks++;
        if (got[63:32] !== e[63:32]) begin
            n_fail++;
            $display("FAIL %s operand1: got %h expected %h", name, got[63:32], e[63:32]);
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        // Empty scoreboard: reading r5 never stalls.
        set_issue(1'b1, 1'b0, 5'd0, 3'd0);
        set_rd(0, 1'b1, 5'd5, 32'h0000_1234);
        step("reset_empty", mk(1'b0, 1'b1, 32'h0000_1234, 32'h0));
`ifdef ID_HAZ_PERF_EN
        n_checks++;
        if (stall_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt);
        end
`endif
    endtask

    task automatic test_load_use();
        clear_inputs();
        set_issue(1'b1, 1'b1, 5'd5, 3'd1);
        step("load_issue", mk(1'b0, 1'b1, 32'h0, 32'h0));
        set_issue(1'b1, 1'b0, 5'd0, 3'd0);
        set_rd(0, 1'b1, 5'd5, 32'h0000_1111);
        step("load_bubble", mk(1'b1, 1'b0, 32'h0000_1111, 32'h0));
        set_fwd(1, 1'b1, 5'd5, 32'hDEAD_BEEF);
        step("load_forward", mk(1'b0, 1'b1, 32'hDEAD_BEEF, 32'h0));
    endtask

    task automatic test_alu_forward();
        clear_inputs();
        set_issue(1'b1, 1'b1, 5'd3, 3'd0);
        step("alu_issue", mk(1'b0, 1'b1, 32'h0, 32'h0));
        set_issue(1'b1, 1'b0, 5'd0, 3'd0);
        set_rd(0, 1'b1, 5'd3, 32'h0000_0099);
        set_fwd(0, 1'b1, 5'd3, 32'h0000_0012);
        step("alu_dependent", mk(1'b0, 1'b1, 32'h0000_0012, 32'h0));
    endtask

    task automatic test_fwd_priority();
        clear_inputs();
        set_issue(1'b1, 1'b0, 5'd0, 3'd0);
        set_rd(0, 1'b1, 5'd7, 32'h0000_0777);
        set_rd(1, 1'b1, 5'd7, 32'h0000_0777);
        set_fwd(0, 1'b1, 5'd7, 32'h0000_AAAA);
        set_fwd(1, 1'b1, 5'd7, 32'h0000_BBBB);
        step("fwd_priority", mk(1'b0, 1'b1, 32'h0000_AAAA, 32'h0000_AAAA));
        // Only the older source matches on port 1.
        set_fwd(0, 1'b1, 5'd6, 32'h0000_AAAA);
        set_rd(1, 1'b1, 5'd7, 32'h0000_0777);
        step("fwd_older_only", mk(1'b0, 1'b1, 32'h0000_BBBB, 32'h0000_BBBB));
    endtask

    task automatic test_flush();
        clear_inputs();
        set_issue(1'b1, 1'b1, 5'd9, 3'd6);
        step("flush_issue", mk(1'b0, 1'b1, 32'h0, 32'h0));
        set_issue(1'b1, 1'b0, 5'd0, 3'd0);
        set_rd(0, 1'b1, 5'd9, 32'h0000_0009);
        step("flush_busy", mk(1'b1, 1'b0, 32'h0000_0009, 32'h0));
        bus.flush_i = 1'b1;
        step("flush_cycle", mk(1'b0, 1'b0, 32'h0000_0009, 32'h0));
        bus.flush_i = 1'b0;
        step("flush_after", mk(1'b0, 1'b1, 32'h0000_0009, 32'h0));
    endtask

    task automatic test_zero_reg();
        clear_inputs();
        set_issue(1'b1, 1'b0, 5'd0, 3'd0);
        set_rd(0, 1'b1, 5'd0, 32'h0000_5555);
        set_rd(1, 1'b0, 5'd4, 32'h0000_5555);
        set_fwd(0, 1'b1, 5'd0, 32'h0000_FFFF);
        set_fwd(1, 1'b1, 5'd0, 32'h0000_FFFF);
        step("zero_reg", mk(1'b0, 1'b1, 32'h0, 32'h0));
        // Writing r0 with a latency must not create a busy entry.
        clear_inputs();
        set_issue(1'b1, 1'b1, 5'd0, 3'd5);
        step("zero_reg_write", mk(1'b0, 1'b1, 32'h0, 32'h0));
        set_issue(1'b1, 1'b0, 5'd0, 3'd0);
        set_rd(1, 1'b1, 5'd0, 32'h0000_5555);
        step("zero_reg_read", mk(1'b0, 1'b1, 32'h0, 32'h0));
    endtask

    task automatic test_back_to_back();
        clear_inputs();
        set_issue(1'b1, 1'b1, 5'd4, 3'd5);
        step("b2b_first", mk(1'b0, 1'b1, 32'h0, 32'h0));
        set_issue(1'b1, 1'b1, 5'd4, 3'd1);
        step("b2b_second", mk(1'b0, 1'b1, 32'h0, 32'h0));
        set_issue(1'b1, 1'b0, 5'd0, 3'd0);
        set_rd(1, 1'b1, 5'd4, 32'h0000_0044);
        step("b2b_stall", mk(1'b1, 1'b0, 32'h0, 32'h0000_0044));
        step("b2b_release", mk(1'b0, 1'b1, 32'h0, 32'h0000_0044));
    endtask

    task automatic test_reset_mid();
        clear_inputs();
        set_issue(1'b1, 1'b1, 5'd2, 3'd4);
        step("rstmid_issue", mk(1'b0, 1'b1, 32'h0, 32'h0));
        set_issue(1'b1, 1'b0, 5'd0, 3'd0);
        set_rd(0, 1'b1, 5'd2, 32'h0000_0022);
        step("rstmid_stall1", mk(1'b1, 1'b0, 32'h0000_0022, 32'h0));
        rst = 1'b1;
        step("rstmid_stall2", mk(1'b1, 1'b0, 32'h0000_0022, 32'h0));
        rst = 1'b0;
        step("rstmid_after", mk(1'b0, 1'b1, 32'h0000_0022, 32'h0));
`ifdef ID_HAZ_PERF_EN
        n_checks++;
        if (stall_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL rstmid_stall_cnt: got %0d expected 0", stall_cnt);
        end
        // Uninterrupted lat=4 writer: exactly four stall cycles counted.
        clear_inputs();
        set_issue(1'b1, 1'b1, 5'd2, 3'd4);
        step("perf_issue", mk(1'b0, 1'b1, 32'h0, 32'h0));
        set_issue(1'b1, 1'b0, 5'd0, 3'd0);
        set_rd(0, 1'b1, 5'd2, 32'h0000_0022);
        for (int k = 0; k < 4; k++) begin
            step("perf_stall", mk(1'b1, 1'b0, 32'h0000_0022, 32'h0));
        end
        step("perf_release", mk(1'b0, 1'b1, 32'h0000_0022, 32'h0));
        n_checks++;
        if (stall_cnt !== 32'd4) begin
            n_fail++;
            $display("FAIL perf_stall_cnt: got %0d expected 4", stall_cnt);
        end
`endif
    endtask

    // Random traffic against a small reference scoreboard built from the
    // documented behaviour.
    task automatic test_random();
        int          cnt_m [32];
        logic        en [2];
        logic [4:0]  a [2];
        logic [31:0] d [2];
        logic [31:0] op [2];
        logic        fw [2];
        logic [4:0]  fd [2];
        logic [31:0] fdata [2];
        logic        iv, iw, fl, hz, st, fi, found;
        logic [4:0]  iwd;
        logic [2:0]  ilat;

        clear_inputs();
        bus.flush_i = 1'b1;
        step("rand_flush0", mk(1'b0, 1'b0, 32'h0, 32'h0));
        for (int r = 0; r < 32; r++) cnt_m[r] = 0;

        for (int n = 0; n < 300; n++) begin
            iv   = 1'($urandom_range(0, 3) != 0);
            iw   = 1'($urandom_range(0, 1));
            iwd  = 5'($urandom_range(0, 7));
            ilat = 3'($urandom_range(0, 7));
            fl   = 1'($urandom_range(0, 19) == 0);
            for (int p = 0; p < 2; p++) begin
                en[p] = 1'($urandom_range(0, 3) != 0);
                a[p]  = 5'($urandom_range(0, 7));
                d[p]  = $urandom;
                fw[p] = 1'($urandom_range(0, 1));
                fd[p] = 5'($urandom_range(0, 7));
                fdata[p] = $urandom;
            end
            hz = 1'b0;
            for (int p = 0; p < 2; p++) begin
                if (en[p] && a[p] != 0 && cnt_m[a[p]] != 0) hz = 1'b1;
                if (!en[p] || a[p] == 0) begin
                    op[p] = 32'h0;
                end else begin
                    op[p] = d[p];
                    found = 1'b0;
                    for (int i = 0; i < 2; i++) begin
                        if (!found && fw[i] && fd[i] == a[p]) begin
                            op[p] = fdata[i];
                            found = 1'b1;
                        end
                    end
                end
            end
            st = iv & hz & ~fl;
            fi = iv & ~st & ~fl;

            set_issue(iv, iw, iwd, ilat);
            bus.flush_i = fl;
            for (int p = 0; p < 2; p++) begin
                set_rd(p, en[p], a[p], d[p]);
                set_fwd(p, fw[p], fd[p], fdata[p]);
            end
            step("random", mk(st, fi, op[0], op[1]));

            for (int r = 1; r < 32; r++) begin
                if (fl) cnt_m[r] = 0;
                else if (cnt_m[r] > 0) cnt_m[r] = cnt_m[r] - 1;
            end
            if (fi && iw && iwd != 0 && ilat != 0) cnt_m[iwd] = (ilat > 7) ? 7 : int'(ilat);
        end
        clear_inputs();
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        clear_inputs();
        test_reset();
        test_load_use();
        test_alu_forward();
        test_fwd_priority();
        test_flush();
        test_zero_reg();
        test_back_to_back();
        test_reset_mid();
        test_random();
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d left expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
